// File: rtl/jtag_tap_sync.sv
// jtag_tap_sync: JTAG TAP responder whose TCK/TMS/TDI/TRSTn pins are
// oversampled in the clk domain. It runs the 16-state TAP controller and
// implements the IDCODE, BYPASS and USER data registers. The USER register
// captures a word from on-chip logic and hands the shifted-in word back at
// Update-DR.
//
// Output handshake: upd_valid_o is a one-clk strobe with no ready/backpressure.
// upd_data_o is refreshed in the same cycle as the strobe and then holds its
// value until the next USER Update-DR or until rst.
module jtag_tap_sync #(
  parameter int                IR_W       = 5,
  parameter int                DATA_W     = 32,
  parameter logic [31:0]       IDCODE_VAL = 32'h1000_0DB1,
  parameter logic [IR_W-1:0]   INS_IDCODE = 5'h01,
  parameter logic [IR_W-1:0]   INS_USER   = 5'h10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tck_i,
  input  logic              tms_i,
  input  logic              tdi_i,
  input  logic              trstn_i,
  output logic              tdo_o,
  output logic              tdo_oe_o,
  input  logic [DATA_W-1:0] cap_data_i,
  output logic [DATA_W-1:0] upd_data_o,
  output logic              upd_valid_o,
  output logic [IR_W-1:0]   ir_o,
  output logic [3:0]        tap_state_o
);

  // Standard 1149.1 state encoding.
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  // Synchronizer stages
  logic tck_s1, tck_s2, tck_s3;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic trst_s1, trst_s2;

  // TAP state and registers
  tap_state_t        state;
  tap_state_t        nxt;
  logic [IR_W-1:0]   ir;
  logic [IR_W-1:0]   ir_sr;
  logic [31:0]       id_sr;
  logic [DATA_W-1:0] user_sr;
  logic              byp_sr;
  logic [DATA_W-1:0] upd_data;
  logic              upd_valid;
  logic              tdo;
  logic              tdo_oe;

  logic rise, fall;
  logic sel_idcode, sel_user;
  logic shift_lsb;

  // Controller transition table.
  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    case (s)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EX1_DR   : SH_DR;
      SH_DR:    next_state = tms ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = tms ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EX1_IR   : SH_IR;
      SH_IR:    next_state = tms ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = tms ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  endfunction

  // Two-flop synchronizers; the third TCK flop feeds edge detection.
  // TRSTn stages reset high so that releasing rst does not look like a TRST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_s1  <= 1'b0;
      tck_s2  <= 1'b0;
      tck_s3  <= 1'b0;
      tms_s1  <= 1'b0;
      tms_s2  <= 1'b0;
      tdi_s1  <= 1'b0;
      tdi_s2  <= 1'b0;
      trst_s1 <= 1'b1;
      trst_s2 <= 1'b1;
    end else begin
      tck_s1  <= tck_i;
      tck_s2  <= tck_s1;
      tck_s3  <= tck_s2;
      tms_s1  <= tms_i;
      tms_s2  <= tms_s1;
      tdi_s1  <= tdi_i;
      tdi_s2  <= tdi_s1;
      trst_s1 <= trstn_i;
      trst_s2 <= trst_s1;
    end
  end

  assign rise = tck_s2 & ~tck_s3;
  assign fall = ~tck_s2 & tck_s3;
  assign nxt  = next_state(state, tms_s2);

  // Any opcode other than IDCODE and USER selects BYPASS.
  assign sel_idcode = (ir == INS_IDCODE);
  assign sel_user   = (ir == INS_USER);

  // Bit presented on TDO while shifting: the IR in Shift-IR, otherwise the
  // data register that the current instruction selects.
  assign shift_lsb = (state == SH_IR) ? ir_sr[0]   :
                     sel_idcode       ? id_sr[0]   :
                     sel_user         ? user_sr[0] : byp_sr;

  // TAP controller plus capture/shift/update of IR and data registers.
  // Synchronized TRSTn takes priority over a rise in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TLR;
      ir         <= INS_IDCODE;
      ir_sr      <= '0;
      id_sr      <= '0;
      user_sr    <= '0;
      byp_sr     <= 1'b0;
      upd_data   <= '0;
      upd_valid  <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      if (!trst_s2) begin
        state <= TLR;
        ir    <= INS_IDCODE;
      end else if (rise) begin
        state <= nxt;
        case (state)
          CAP_IR: ir_sr <= {{(IR_W-2){1'b0}}, 2'b01};
          SH_IR:  ir_sr <= {tdi_s2, ir_sr[IR_W-1:1]};
          CAP_DR: begin
            if (sel_idcode)    id_sr   <= IDCODE_VAL;
            else if (sel_user) user_sr <= cap_data_i;
            else               byp_sr  <= 1'b0;
          end
          SH_DR: begin
            if (sel_idcode)    id_sr   <= {tdi_s2, id_sr[31:1]};
            else if (sel_user) user_sr <= {tdi_s2, user_sr[DATA_W-1:1]};
            else               byp_sr  <= tdi_s2;
          end
          default: ;
        endcase
        // IR reloads on entry to Update-IR and is forced to IDCODE in TLR.
        if (nxt == UPD_IR) ir <= ir_sr;
        if (nxt == TLR)    ir <= INS_IDCODE;
        // Only USER hands a word back to on-chip logic.
        if (nxt == UPD_DR && sel_user) begin
          upd_data  <= user_sr;
          upd_valid <= 1'b1;
        end
      end
    end
  end

  // TDO and its enable change only on a TCK fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else if (fall) begin
      if (state == SH_IR || state == SH_DR) begin
        tdo    <= shift_lsb;
        tdo_oe <= 1'b1;
      end else begin
        tdo    <= 1'b0;
        tdo_oe <= 1'b0;
      end
    end
  end

  assign tdo_o       = tdo;
  assign tdo_oe_o    = tdo_oe;
  assign upd_data_o  = upd_data;
  assign upd_valid_o = upd_valid;
  assign ir_o        = ir;
  assign tap_state_o = state;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// tb_jtag_tap_sync: directed JTAG sequences against jtag_tap_sync. A
// scoreboard holds expected TDO/enable pairs and expected USER update words.
// A monitor pops them when the driver strobes a TDO sample point or when the
// DUT raises upd_valid_o.
module tb_jtag_tap_sync;

  localparam int          IR_W       = 5;
  localparam int          DATA_W     = 32;
  localparam logic [31:0] IDCODE_VAL = 32'h1000_0DB1;

  logic              clk;
  logic              rst;
  logic              tck_i, tms_i, tdi_i, trstn_i;
  logic              tdo_o, tdo_oe_o;
  logic [DATA_W-1:0] cap_data_i;
  logic [DATA_W-1:0] upd_data_o;
  logic              upd_valid_o;
  logic [IR_W-1:0]   ir_o;
  logic [3:0]        tap_state_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queues
  logic [1:0]        exp_q[$];      // {tdo_oe, tdo}
  string             name_q[$];
  logic [DATA_W-1:0] exp_upd_q[$];
  logic              tdo_strobe;

  jtag_tap_sync #(
    .IR_W       (IR_W),
    .DATA_W     (DATA_W),
    .IDCODE_VAL (IDCODE_VAL),
    .INS_IDCODE (5'h01),
    .INS_USER   (5'h10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tck_i       (tck_i),
    .tms_i       (tms_i),
    .tdi_i       (tdi_i),
    .trstn_i     (trstn_i),
    .tdo_o       (tdo_o),
    .tdo_oe_o    (tdo_oe_o),
    .cap_data_i  (cap_data_i),
    .upd_data_o  (upd_data_o),
    .upd_valid_o (upd_valid_o),
    .ir_o        (ir_o),
    .tap_state_o (tap_state_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  // Compares TDO at strobed sample points and every upd_valid_o pulse.
  always @(negedge clk) begin
    if (tdo_strobe) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tdo_sample: got sample {oe,tdo}=%b%b, required a queued expectation", tdo_oe_o, tdo_o);
      end else begin
        check(name_q.pop_front(), {30'd0, tdo_oe_o, tdo_o}, {30'd0, exp_q.pop_front()});
      end
    end
    if (upd_valid_o === 1'b1) begin
      if (exp_upd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL upd_valid_unexpected: got pulse with data %h, required no pulse", upd_data_o);
      end else begin
        check("upd_data_at_pulse", upd_data_o, exp_upd_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One full TCK period: TMS/TDI set up, TCK high 6 clk, low 6 clk.
  task automatic tck_cycle(input logic tms, input logic tdi);
    @(posedge clk);
    tms_i = tms;
    tdi_i = tdi;
    repeat (2) @(posedge clk);
    tck_i = 1'b1;
    repeat (6) @(posedge clk);
    tck_i = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // TCK period followed by a TDO sample point with its expectation queued.
  task automatic tck_chk(input logic tms, input logic tdi, input logic [1:0] exp, input string name);
    tck_cycle(tms, tdi);
    exp_q.push_back(exp);
    name_q.push_back(name);
    tdo_strobe = 1'b1;
    @(posedge clk);
    tdo_strobe = 1'b0;
  endtask

  // From a Capture state: enter Shift, shift n bits of din LSB-first, leave
  // to Exit1. dout is the bit stream expected on TDO, LSB-first.
  task automatic shift_reg(input int n, input logic [31:0] din, input logic [31:0] dout, input string name);
    tck_chk(1'b0, 1'b0, {1'b1, dout[0]}, name);
    for (int i = 0; i < n - 1; i++) tck_chk(1'b0, din[i], {1'b1, dout[i+1]}, name);
    tck_chk(1'b1, din[n-1], 2'b00, {name, "_exit"});
  endtask

  // From RTI: load an instruction, checking the captured IR pattern, and
  // return to RTI.
  task automatic load_ir(input logic [4:0] op);
    logic [31:0] din;
    din = {27'd0, op};
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    shift_reg(IR_W, din, 32'h0000_0001, "ir_capture_tdo");
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  // From RTI to Capture-DR.
  task automatic goto_cap_dr();
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    tck_i      = 1'b0;
    tms_i      = 1'b0;
    tdi_i      = 1'b0;
    trstn_i    = 1'b1;
    cap_data_i = '0;
    tdo_strobe = 1'b0;

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, tap_state_o}, 32'h0000_000F);
    check("reset_ir", {27'd0, ir_o}, 32'h0000_0001);
    check("reset_tdo", {31'd0, tdo_o}, 32'd0);
    check("reset_tdo_oe", {31'd0, tdo_oe_o}, 32'd0);
    check("reset_upd_valid", {31'd0, upd_valid_o}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // IDCODE read
    tck_cycle(1'b0, 1'b0);
    goto_cap_dr();
    shift_reg(32, 32'h0, IDCODE_VAL, "idcode_tdo");
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("idcode_back_in_rti", {28'd0, tap_state_o}, 32'h0000_000C);

    // BYPASS: all-ones opcode, then 1,0,1,1 in gives 0,1,0,1 out
    load_ir(5'h1F);
    @(negedge clk);
    check("ir_bypass", {27'd0, ir_o}, 32'h0000_001F);
    goto_cap_dr();
    shift_reg(4, 32'h0000_000D, 32'h0000_000A, "bypass_tdo");
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);

    // USER write/read
    load_ir(5'h10);
    @(negedge clk);
    check("ir_user", {27'd0, ir_o}, 32'h0000_0010);
    cap_data_i = 32'h1234_5678;
    goto_cap_dr();
    shift_reg(32, 32'hDEAD_BEEF, 32'h1234_5678, "user_tdo");
    exp_upd_q.push_back(32'hDEAD_BEEF);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("user_upd_data_hold", upd_data_o, 32'hDEAD_BEEF);

    // TMS reset from Shift-DR. The path passes through Update-DR under USER,
    // so the capture word shifted once with TDI=0 is handed back.
    cap_data_i = 32'hA5A5_0F0F;
    goto_cap_dr();
    tck_cycle(1'b0, 1'b0);
    exp_upd_q.push_back(32'h52D2_8787);
    repeat (5) tck_cycle(1'b1, 1'b0);
    @(negedge clk);
    check("tms_reset_state", {28'd0, tap_state_o}, 32'h0000_000F);
    check("tms_reset_ir", {27'd0, ir_o}, 32'h0000_0001);
    check("tms_reset_upd_data", upd_data_o, 32'h52D2_8787);

    // TRSTn low in the middle of a USER Shift-DR
    tck_cycle(1'b0, 1'b0);
    load_ir(5'h10);
    cap_data_i = 32'h0;
    goto_cap_dr();
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1);
    tck_cycle(1'b0, 1'b1);
    @(posedge clk);
    trstn_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("trst_state", {28'd0, tap_state_o}, 32'h0000_000F);
    check("trst_ir", {27'd0, ir_o}, 32'h0000_0001);
    check("trst_upd_data", upd_data_o, 32'h52D2_8787);
    check("trst_upd_valid", {31'd0, upd_valid_o}, 32'd0);
    trstn_i = 1'b1;
    repeat (4) @(posedge clk);

    // rst pulse right after entering USER Shift-DR (TDO driven high)
    tck_cycle(1'b0, 1'b0);
    load_ir(5'h10);
    cap_data_i = 32'h0000_0001;
    goto_cap_dr();
    tck_chk(1'b0, 1'b0, 2'b11, "pre_rst_tdo");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_state", {28'd0, tap_state_o}, 32'h0000_000F);
    check("rst_ir", {27'd0, ir_o}, 32'h0000_0001);
    check("rst_tdo", {31'd0, tdo_o}, 32'd0);
    check("rst_tdo_oe", {31'd0, tdo_oe_o}, 32'd0);
    check("rst_upd_data", upd_data_o, 32'd0);
    check("rst_upd_valid", {31'd0, upd_valid_o}, 32'd0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Clean IDCODE read after the reset
    tck_cycle(1'b0, 1'b0);
    goto_cap_dr();
    shift_reg(32, 32'hFFFF_FFFF, IDCODE_VAL, "idcode_after_rst");

    // Every queued expectation must have been consumed
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("tdo_queue_drained", exp_q.size(), 32'd0);
    check("upd_queue_drained", exp_upd_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
